axis_data_sfifo_pkt: RTL and testbench
======================================

// Module: axis_data_sfifo_pkt
// PURPOSE
//  Next-generation AXI-Stream sync FIFO: inferable dual-port BRAM store, 1 beat/clk sustained,
//  carries tdata+tlast+tuser, exposes fill level and programmable almost-full/almost-empty flags.
//  Optional store-and-forward packet mode. Sits between stream producers/consumers in one clock domain.
// PARAMETERS
//  DEPTH      8192        RAM entries = total capacity in words; power of two, >= 4
//  DW         24          tdata width
//  UW         1           tuser width, >= 1
//  AF_THRESH  DEPTH-4     almost_full when data_count >= AF_THRESH
//  AE_THRESH  4           almost_empty when data_count <= AE_THRESH
//  (local) CW = $clog2(DEPTH)+1
// PORTS
//  clk            in   1      single clock
//  reset          in   1      synchronous, active-high
//  s_axis_tvalid  in   1      input beat valid
//  s_axis_tready  out  1      input ready
//  s_axis_tdata   in   DW     input data
//  s_axis_tlast   in   1      end of packet
//  s_axis_tuser   in   UW     sideband, travels with beat
//  m_axis_tvalid  out  1      output beat valid
//  m_axis_tready  in   1      output ready
//  m_axis_tdata   out  DW     output data
//  m_axis_tlast   out  1      output end of packet
//  m_axis_tuser   out  UW     output sideband
//  data_count     out  CW     words accepted minus words delivered (0..DEPTH)
//  almost_full    out  1      data_count >= AF_THRESH
//  almost_empty   out  1      data_count <= AE_THRESH
//  pkt_count      out  CW     complete packets held (only with AXIS_SFIFO_PACKET_MODE_EN)
// BEHAVIOUR
//  - One clock; reset synchronous active-high. While reset high: s_axis_tready=0, m_axis_tvalid=0,
//    data_count=0, almost_full=0, almost_empty=1, pkt_count=0; pointers cleared. Reset mid-transfer
//    discards all stored and in-flight words; s_axis_tready=1 the cycle after reset drops.
//  - Accept on s_axis_tvalid&s_axis_tready; deliver on m_axis_tvalid&m_axis_tready.
//  - s_axis_tready = ~reset & (data_count < DEPTH); capacity exactly DEPTH incl. output stages.
//  - data_count register: +1 on accept, -1 on deliver, unchanged on both; flags derived from it,
//    updated in the same cycle as data_count.
//  - Read path: registered BRAM read + output register with skid; empty FIFO, accept at cycle N ->
//    m_axis_tvalid at N+2. Back-to-back beats with m_axis_tready=1 stream at 1 beat/clk, no bubbles.
//  - AXIS rules: once m_axis_tvalid=1 it stays 1 and tdata/tlast/tuser stay stable until handshake.
//    Order preserved; tlast/tuser bit-exact with their tdata.
//  - Pointers AW+1 bits, wrap mod DEPTH on index; full/empty never ambiguous at wrap.
//  - Full and simultaneous deliver: accept allowed only if data_count<DEPTH at cycle start
//    (no same-cycle pass-through of ready).
// CONFIGURATION
//  AXIS_SFIFO_PACKET_MODE_EN defined: store-and-forward.
//   - pkt_count +1 on accept with tlast, -1 on deliver with tlast, unchanged on both.
//   - m_axis_tvalid gated: asserted only if head beat valid & (pkt_count!=0 | cut_through).
//   - cut_through set when data_count==DEPTH & pkt_count==0 (oversize packet, deadlock escape);
//     cleared on delivery of a tlast beat. Gating never drops an already-asserted tvalid.
//  Not defined: cut-through FIFO, tlast ignored for flow control, pkt_count port tied to 0.
// TESTING
//  1 Reset: hold reset 3 clk -> tready=0,tvalid=0,count=0,almost_empty=1; release -> tready=1 next clk.
//  2 Latency/throughput: DEPTH=16, write 0x1..0x10 back-to-back, m_tready=1 -> first tvalid at N+2,
//    16 beats consecutive, data in order, count returns to 0.
//  3 Full/wrap: m_tready=0, write 16 beats -> tready=0 after 16th, count=16, almost_full=1 (AF=12);
//    drain 8, write 8 more (pointer wrap) -> all 24 read back in order.
//  4 Backpressure: random m_tready 50%, 1000 beats random tdata/tlast/tuser -> scoreboard match,
//    tdata stable while tvalid&~tready.
//  5 Packet mode: write 5-beat packet holding last beat 10 clk -> m_tvalid=0 until tlast accepted,
//    then 5 beats out, pkt_count 1->0.
//  6 Packet mode oversize: DEPTH=16, 20-beat packet, m_tready=1 -> cut_through at count=16,
//    all 20 beats delivered, no deadlock; reset mid-packet -> count=0, pkt_count=0.

Source files
------------

// File: rtl/axis_data_sfifo_pkt.sv
// axis_data_sfifo_pkt: AXI-Stream synchronous FIFO on an inferred dual-port RAM with fill-level flags.
// Define AXIS_SFIFO_PACKET_MODE_EN for store-and-forward packet mode (pkt_count, tvalid gating).
module axis_data_sfifo_pkt #(
  parameter int DEPTH     = 8192,
  parameter int DW        = 24,
  parameter int UW        = 1,
  parameter int AF_THRESH = DEPTH - 4,
  parameter int AE_THRESH = 4,
  localparam int CW       = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          s_axis_tvalid,
  output logic          s_axis_tready,
  input  logic [DW-1:0] s_axis_tdata,
  input  logic          s_axis_tlast,
  input  logic [UW-1:0] s_axis_tuser,
  output logic          m_axis_tvalid,
  input  logic          m_axis_tready,
  output logic [DW-1:0] m_axis_tdata,
  output logic          m_axis_tlast,
  output logic [UW-1:0] m_axis_tuser,
  output logic [CW-1:0] data_count,
  output logic          almost_full,
  output logic          almost_empty,
  output logic [CW-1:0] pkt_count
);
  localparam int AW = CW - 1;
  localparam int MW = DW + 1 + UW;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  logic [MW-1:0] mem [DEPTH];
  logic [MW-1:0] rd_data_q;
  logic [CW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] data_count_q, data_count_d;
  logic          out_valid_q, out_valid_d;
  logic          almost_full_q, almost_full_d;
  logic          almost_empty_q, almost_empty_d;
  logic          accept, deliver, rd_en, out_open;

`ifdef AXIS_SFIFO_PACKET_MODE_EN
  logic [CW-1:0] pkt_count_q, pkt_count_d;
  logic          cut_through_q, cut_through_d;
  logic          pkt_inc, pkt_dec;

  // Head beat is released only once its packet is complete, or when a packet too large to fit stalls.
  assign out_open  = (pkt_count_q != '0) | cut_through_q;
  assign pkt_count = pkt_count_q;
  assign pkt_inc   = accept & s_axis_tlast;
  assign pkt_dec   = deliver & m_axis_tlast;

  always_comb begin
    pkt_count_d   = pkt_count_q;
    cut_through_d = cut_through_q;
    if (pkt_inc & ~pkt_dec) begin
      pkt_count_d = pkt_count_q + ONE_C;
    end else if (pkt_dec & ~pkt_inc) begin
      pkt_count_d = pkt_count_q - ONE_C;
    end
    if (pkt_dec) begin
      cut_through_d = 1'b0;
    end else if ((data_count_q == DEPTH_C) && (pkt_count_q == '0)) begin
      cut_through_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pkt_count_q   <= '0;
      cut_through_q <= 1'b0;
    end else begin
      pkt_count_q   <= pkt_count_d;
      cut_through_q <= cut_through_d;
    end
  end
`else
  assign out_open  = 1'b1;
  assign pkt_count = '0;
`endif

  assign s_axis_tready = ~reset & (data_count_q < DEPTH_C);
  assign m_axis_tvalid = ~reset & out_valid_q & out_open;
  assign accept        = s_axis_tvalid & s_axis_tready;
  assign deliver       = m_axis_tvalid & m_axis_tready;
  // Refill the output register whenever it is empty or being drained this cycle.
  assign rd_en         = (wr_ptr_q != rd_ptr_q) & (~out_valid_q | deliver);

  assign {m_axis_tuser, m_axis_tlast, m_axis_tdata} = rd_data_q;
  assign data_count   = data_count_q;
  assign almost_full  = almost_full_q;
  assign almost_empty = almost_empty_q;

  always_comb begin
    wr_ptr_d     = wr_ptr_q + CW'(accept);
    rd_ptr_d     = rd_ptr_q + CW'(rd_en);
    out_valid_d  = rd_en | (out_valid_q & ~deliver);
    data_count_d = data_count_q;
    if (accept & ~deliver) begin
      data_count_d = data_count_q + ONE_C;
    end else if (deliver & ~accept) begin
      data_count_d = data_count_q - ONE_C;
    end
    almost_full_d  = (data_count_d >= AF_C);
    almost_empty_d = (data_count_d <= AE_C);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      data_count_q   <= '0;
      out_valid_q    <= 1'b0;
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      data_count_q   <= data_count_d;
      out_valid_q    <= out_valid_d;
      almost_full_q  <= almost_full_d;
      almost_empty_q <= almost_empty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr_q[AW-1:0]] <= {s_axis_tuser, s_axis_tlast, s_axis_tdata};
    end
  end

  // Registered RAM read doubles as the output stage; it holds while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data_q <= mem[rd_ptr_q[AW-1:0]];
    end
  end
endmodule

// File: tb/tb_axis_data_sfifo_pkt.sv
// Randomized scoreboard bench for axis_data_sfifo_pkt (DEPTH=16); packet tests run when
// AXIS_SFIFO_PACKET_MODE_EN is defined.
`timescale 1ns/1ps
module tb_axis_data_sfifo_pkt;
  localparam int DEPTH = 16;
  localparam int DW    = 16;
  localparam int UW    = 2;
  localparam int AF    = 12;
  localparam int AE    = 4;
  localparam int CW    = 5;
  localparam int BW    = DW + 1 + UW;
`ifdef AXIS_SFIFO_PACKET_MODE_EN
  localparam bit PKT = 1'b1;
`else
  localparam bit PKT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [DW-1:0] s_data = '0;
  logic          s_last = 1'b0;
  logic [UW-1:0] s_user = '0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic [UW-1:0] m_user;
  logic [CW-1:0] data_count;
  logic [CW-1:0] pkt_count;
  logic          almost_full;
  logic          almost_empty;

  int vectors = 0;
  int miscompares = 0;
  int rst_edges = 0;

  // Reference model: ordered list of accepted beats plus spec-level occupancy bookkeeping.
  logic [BW-1:0] exp_q[$];
  int  exp_count = 0;
  int  exp_pkts = 0;
  bit  cut_m = 1'b0;
  bit  prev_stall = 1'b0;
  logic [BW-1:0] prev_beat = '0;
  int  accepted = 0;
  int  delivered = 0;
  int  max_count = 0;

  axis_data_sfifo_pkt #(
    .DEPTH(DEPTH), .DW(DW), .UW(UW), .AF_THRESH(AF), .AE_THRESH(AE)
  ) dut (
    .clk(clk), .reset(reset),
    .s_axis_tvalid(s_valid), .s_axis_tready(s_ready), .s_axis_tdata(s_data),
    .s_axis_tlast(s_last), .s_axis_tuser(s_user),
    .m_axis_tvalid(m_valid), .m_axis_tready(m_ready), .m_axis_tdata(m_data),
    .m_axis_tlast(m_last), .m_axis_tuser(m_user),
    .data_count(data_count), .almost_full(almost_full), .almost_empty(almost_empty),
    .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) rst_edges <= reset ? rst_edges + 1 : 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares DUT state and delivered beats against the model at every falling edge.
  always @(negedge clk) begin
    logic [BW-1:0] got;
    if (reset) begin
      exp_q.delete();
      exp_count = 0;
      exp_pkts = 0;
      cut_m = 1'b0;
      prev_stall = 1'b0;
      if (rst_edges >= 1) begin
        chk("rst_tready", s_ready, 0);
        chk("rst_tvalid", m_valid, 0);
        chk("rst_count", data_count, 0);
        chk("rst_almost_full", almost_full, 0);
        chk("rst_almost_empty", almost_empty, 1);
        chk("rst_pkt_count", pkt_count, 0);
      end
    end else begin
      chk("data_count", data_count, exp_count);
      chk("tready", s_ready, exp_count < DEPTH);
      chk("almost_full", almost_full, exp_count >= AF);
      chk("almost_empty", almost_empty, exp_count <= AE);
      if (PKT) begin
        chk("pkt_count", pkt_count, exp_pkts);
        if (exp_pkts == 0 && !cut_m && !prev_stall) chk("pkt_gate", m_valid, 0);
      end else begin
        chk("pkt_count", pkt_count, 0);
      end
      if (prev_stall) begin
        chk("hold_tvalid", m_valid, 1);
        chk("hold_beat", {m_user, m_last, m_data}, prev_beat);
      end
      if (m_valid && m_ready && m_last) cut_m = 1'b0;
      else if (exp_count == DEPTH && exp_pkts == 0) cut_m = 1'b1;
      if (m_valid && m_ready) begin
        delivered++;
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL beat_underflow: got 0x%0h required no delivery", {m_user, m_last, m_data});
        end else begin
          got = exp_q.pop_front();
          chk("beat", {m_user, m_last, m_data}, got);
          if (got[DW]) exp_pkts--;
        end
        exp_count--;
      end
      if (s_valid && s_ready) begin
        exp_q.push_back({s_user, s_last, s_data});
        exp_count++;
        if (s_last) exp_pkts++;
        accepted++;
      end
      prev_stall = m_valid & ~m_ready;
      prev_beat  = {m_user, m_last, m_data};
      if (int'(data_count) > max_count) max_count = int'(data_count);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    s_valid = 1'b0;
    m_ready = 1'b0;
    repeat (n) tick();
    reset = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    s_valid = 1'b0;
    m_ready = 1'b1;
    while (exp_count != 0 && n < 400) begin
      tick();
      n++;
    end
    chk(name, data_count, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int first, last_v, nv, d0, n, a, acc0, a_snap;

    // Reset held for three clocks, then tready rises.
    do_reset(3);
    @(negedge clk);
    chk("post_reset_tready", s_ready, 1);
    tick();

    // Latency and throughput: 16 back-to-back beats.
    first = -1; last_v = -1; nv = 0;
    m_ready = 1'b1;
    for (int i = 0; i < 22; i++) begin
      s_valid = (i < 16);
      s_data  = DW'(i + 1);
      s_last  = PKT ? 1'b1 : (i == 15);
      s_user  = UW'(i);
      @(negedge clk);
      if (m_valid) begin
        if (first < 0) first = i;
        last_v = i;
        nv++;
      end
      tick();
    end
    chk("first_tvalid_latency", first, 2);
    chk("stream_span", last_v - first + 1, 16);
    chk("stream_beats", nv, 16);
    chk("stream_count_zero", data_count, 0);

    // Fill to capacity, partial drain, refill across the pointer wrap.
    m_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      s_valid = 1'b1;
      s_data  = DW'(16'h0100 + i);
      s_last  = PKT ? 1'b1 : (i[1:0] == 2'd3);
      s_user  = UW'(i + 1);
      tick();
    end
    s_valid = 1'b1;
    s_data  = 16'hdead;
    @(negedge clk);
    chk("full_tready", s_ready, 0);
    chk("full_count", data_count, 16);
    chk("full_almost_full", almost_full, 1);
    tick();
    s_valid = 1'b0;
    d0 = delivered; n = 0;
    while (delivered - d0 < 8 && n < 50) begin
      m_ready = 1'b1;
      tick();
      n++;
    end
    m_ready = 1'b0;
    chk("half_drain_count", data_count, 8);
    for (int i = 0; i < 8; i++) begin
      s_valid = 1'b1;
      s_data  = DW'(16'h0200 + i);
      s_last  = 1'b1;
      s_user  = UW'(i);
      tick();
    end
    drain("wrap_drain");

    // Random traffic with random backpressure.
    acc0 = accepted; n = 0; a_snap = accepted;
    while (accepted - acc0 < 1000 && n < 20000) begin
      if (!s_valid || accepted != a_snap) begin
        s_valid = ($urandom_range(0, 9) < 7);
        s_data  = DW'($urandom);
        s_last  = ($urandom_range(0, 3) == 0) || (accepted - acc0 == 999);
        s_user  = UW'($urandom);
      end
      m_ready = $urandom_range(0, 1) == 1;
      a_snap = accepted;
      tick();
      n++;
    end
    chk("random_beats_accepted", accepted - acc0, 1000);
    drain("random_drain");

    // Reset in the middle of a transfer discards everything.
    m_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      s_valid = 1'b1;
      s_data  = DW'(16'h0300 + i);
      s_last  = 1'b0;
      tick();
    end
    do_reset(3);
    @(negedge clk);
    chk("midreset_count", data_count, 0);
    chk("midreset_tready", s_ready, 1);
    tick();

    if (PKT) begin
      // Store-and-forward: nothing leaves until the tlast beat is in.
      m_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
        s_valid = 1'b1;
        s_data  = DW'(16'h0400 + i);
        s_last  = 1'b0;
        tick();
      end
      s_valid = 1'b0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        chk("pkt_hold_tvalid", m_valid, 0);
        tick();
      end
      s_valid = 1'b1;
      s_data  = 16'h0404;
      s_last  = 1'b1;
      tick();
      s_valid = 1'b0;
      d0 = delivered;
      @(negedge clk);
      chk("pkt_count_one", pkt_count, 1);
      n = 0;
      while (delivered - d0 < 5 && n < 40) begin
        tick();
        n++;
      end
      chk("pkt_beats_out", delivered - d0, 5);
      tick();
      chk("pkt_count_zero", pkt_count, 0);

      // Oversize packet escapes through cut-through.
      max_count = 0;
      d0 = delivered;
      m_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
        a = accepted;
        s_valid = 1'b1;
        s_data  = DW'(16'h0500 + i);
        s_last  = (i == 19);
        s_user  = UW'(i);
        n = 0;
        do begin
          tick();
          n++;
        end while (accepted == a && n < 100);
      end
      s_valid = 1'b0;
      n = 0;
      while (delivered - d0 < 20 && n < 100) begin
        tick();
        n++;
      end
      chk("oversize_delivered", delivered - d0, 20);
      chk("oversize_peak_count", max_count, 16);

      m_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
        s_valid = 1'b1;
        s_data  = DW'(16'h0600 + i);
        s_last  = 1'b0;
        tick();
      end
      do_reset(3);
      @(negedge clk);
      chk("pkt_midreset_count", data_count, 0);
      chk("pkt_midreset_pkt_count", pkt_count, 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
